bcd_score_accumulator: RTL and testbench

//   Parametrised score unit: adds a variable BCD increment to a SCORE_DIGITS-wide BCD score,
//   one digit per clock, saturating at all-9s. Tracks a high score; drives the 7-seg bank

---
 rtl/bcd_score_accumulator_pkg.sv | 35 +++
 rtl/bcd_score_accumulator_digit_adder.sv | 31 +++
 rtl/bcd_score_accumulator.sv | 176 +++++++++++++++++
 tb/tb_bcd_score_accumulator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_score_accumulator_pkg.sv
// Shared definitions for the BCD score accumulator: digit width and limits,
// the blank segment pattern, the FSM state encoding and the 7-segment lookup.
package bcd_score_accumulator_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0] SEG_BLANK     = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_CMP  = 2'd2
  } state_e;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always off.
  // Non-decimal codes never reach the display, so they show as blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_score_accumulator_digit_adder.sv
// One-digit BCD adder with +6 correction.
// Ports: a, b  - BCD digits (0-9)
//        cin   - carry in from the lower digit
//        sum   - BCD sum digit
//        cout  - decimal carry out
module bcd_digit_adder
  import bcd_score_accumulator_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] sum,
  output logic                   cout
);

  logic [BCD_DIGIT_W:0] raw;
  logic [BCD_DIGIT_W:0] corr;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
    corr = raw + 5'd6;
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum  = corr[BCD_DIGIT_W-1:0];
      cout = 1'b1;
    end else begin
      sum  = raw[BCD_DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_score_accumulator.sv
// BCD score accumulator: adds a BCD increment to the score one digit per clock
// through a single time-shared digit adder, saturates at all-9s, tracks the
// high score and drives the 7-segment bank with optional leading-zero blanking.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   start, increment      - add request and its BCD addend (taken when ready)
//   clear                 - zero score/overflow, abort any add (highest priority)
//   showHigh              - display select: 0 score, 1 high score
//   ready, done           - idle flag, one-cycle add-complete pulse
//   overflow              - sticky saturation flag
//   score, highScore      - packed BCD values
//   display               - 8 bits per digit, active-low segments
module bcd_score_accumulator
  import bcd_score_accumulator_pkg::*;
#(
  parameter int SCORE_DIGITS   = 6,
  parameter int INC_DIGITS     = 2,
  parameter int BLANK_LEADING  = 1,
  parameter int SCORE_BITWIDTH = 4 * SCORE_DIGITS,
  parameter int DISPLAY_MSB    = 8 * SCORE_DIGITS - 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [4*INC_DIGITS-1:0]   increment,
  input  logic                      clear,
  input  logic                      showHigh,
  output logic                      ready,
  output logic                      done,
  output logic                      overflow,
  output logic [SCORE_BITWIDTH-1:0] score,
  output logic [SCORE_BITWIDTH-1:0] highScore,
  output logic [DISPLAY_MSB:0]      display
);

  localparam int              IDX_W    = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCORE_DIGITS - 1);

  state_e                    state_q;
  logic [SCORE_BITWIDTH-1:0] score_q, high_q, inc_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      carry_q, ovf_q, done_q, ready_q;

  logic [BCD_DIGIT_W-1:0]    add_a, add_b, add_sum;
  logic                      add_cout;
  logic [SCORE_BITWIDTH-1:0] score_d;

  // Clamp each increment digit to 9 and zero-extend to the score width.
  function automatic logic [SCORE_BITWIDTH-1:0] clamp_inc(input logic [4*INC_DIGITS-1:0] v);
    logic [SCORE_BITWIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < INC_DIGITS; i++) begin
      if (v[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT)
        r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = BCD_MAX_DIGIT;
      else
        r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = v[BCD_DIGIT_W*i +: BCD_DIGIT_W];
    end
    return r;
  endfunction

  // A carry out of the MSD pins the score at all-9s.
  function automatic logic [SCORE_BITWIDTH-1:0] saturate(input logic [SCORE_BITWIDTH-1:0] v,
                                                         input logic                      cout);
    logic [SCORE_BITWIDTH-1:0] r;
    r = v;
    if (cout) begin
      for (int i = 0; i < SCORE_DIGITS; i++) r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = BCD_MAX_DIGIT;
    end
    return r;
  endfunction

  // Operand select for the shared adder, and write-back of its sum.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    score_d = score_q;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a = score_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
        add_b = inc_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
        score_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] = add_sum;
      end
    end
  end

  bcd_digit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      high_q  <= '0;
      inc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        // Aborts any add in flight; the high score is deliberately kept.
        state_q <= ST_IDLE;
        score_q <= '0;
        ovf_q   <= 1'b0;
        idx_q   <= '0;
        carry_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              inc_q   <= clamp_inc(increment);
              idx_q   <= '0;
              carry_q <= 1'b0;
              ready_q <= 1'b0;
              state_q <= ST_ADD;
            end
          end
          ST_ADD: begin
            if (idx_q == LAST_IDX) begin
              score_q <= saturate(score_d, add_cout);
              if (add_cout) ovf_q <= 1'b1;
              state_q <= ST_CMP;
            end else begin
              score_q <= score_d;
              carry_q <= add_cout;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
          ST_CMP: begin
            // Packed BCD orders the same as its decimal value.
            if (score_q > high_q) high_q <= score_q;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign score     = score_q;
  assign highScore = high_q;

  // Display: scan from the MSD; digits stay blank until the first nonzero one.
  logic [SCORE_BITWIDTH-1:0] disp_val;
  logic [BCD_DIGIT_W-1:0]    disp_dig;
  logic                      leading;

  always_comb begin
    disp_val = showHigh ? high_q : score_q;
    leading  = 1'b1;
    disp_dig = '0;
    display  = '0;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      disp_dig = disp_val[BCD_DIGIT_W*i +: BCD_DIGIT_W];
      if (disp_dig != '0) leading = 1'b0;
      if ((BLANK_LEADING != 0) && leading && (i != 0))
        display[8*i +: 8] = SEG_BLANK;
      else
        display[8*i +: 8] = seg7(disp_dig);
    end
  end

endmodule

// File: tb/tb_bcd_score_accumulator.sv
module tb_bcd_score_accumulator;

  typedef struct {
    int cyc;
    int score;
    int high;
    bit ovf;
  } exp_t;

  localparam int         DIG [2] = '{6, 2};
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clock = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0, showHigh = 1'b0;
  logic [7:0] increment = 8'h00;

  logic        r0, d0, o0, r1, d1, o1;
  logic [23:0] s0, h0;
  logic [7:0]  s1, h1;
  logic [47:0] disp0;
  logic [15:0] disp1;

  bcd_score_accumulator #(.SCORE_DIGITS(6), .INC_DIGITS(2), .BLANK_LEADING(1)) u_dut (
    .clock(clock), .reset(reset), .start(start), .increment(increment), .clear(clear),
    .showHigh(showHigh), .ready(r0), .done(d0), .overflow(o0), .score(s0),
    .highScore(h0), .display(disp0));

  bcd_score_accumulator #(.SCORE_DIGITS(2), .INC_DIGITS(2), .BLANK_LEADING(0)) u_small (
    .clock(clock), .reset(reset), .start(start), .increment(increment), .clear(clear),
    .showHigh(showHigh), .ready(r1), .done(d1), .overflow(o1), .score(s1),
    .highScore(h1), .display(disp1));

  always #5 clock = ~clock;

  logic        ready_w [2], done_w [2], ovf_w [2];
  logic [23:0] score_w [2], high_w [2];
  logic [47:0] disp_w  [2];

  always_comb begin
    ready_w[0] = r0;  ready_w[1] = r1;
    done_w[0]  = d0;  done_w[1]  = d1;
    ovf_w[0]   = o0;  ovf_w[1]   = o1;
    score_w[0] = s0;  score_w[1] = {16'h0, s1};
    high_w[0]  = h0;  high_w[1]  = {16'h0, h1};
    disp_w[0]  = disp0;
    disp_w[1]  = {32'h0, disp1};
  end

  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  // Reference model: decimal integers, a busy countdown and expected-done queues.
  int   m_score [2], m_high [2], busy [2], p_score [2];
  bit   m_ovf [2], p_ovf [2];
  exp_t q0 [$], q1 [$];
  int   n_cmp = 0, n_fail = 0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int inc_value(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [23:0] to_bcd(input int v, input int nd);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [47:0] exp_disp(input int v, input int nd, input bit blank);
    logic [47:0] r;
    int sig, t;
    r = '0;
    sig = 1;
    t = v / 10;
    while (t > 0) begin
      sig++;
      t = t / 10;
    end
    for (int i = 0; i < nd; i++)
      r[8*i +: 8] = (blank && i >= sig) ? 8'hFF : SEG[(v / pow10(i)) % 10];
    return r;
  endfunction

  task automatic check(input string nm, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d edge %0d: got %h expected %h", nm, id, edge_n, act, exp);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void flush(input int id);
    if (id == 0) q0.delete(); else q1.delete();
  endfunction

  // Model of one rising edge given the inputs about to be sampled.
  task automatic model_edge(input int id, input logic s, input logic c, input logic [7:0] inc);
    exp_t e;
    int   v, maxv;
    bit   o;
    maxv = pow10(DIG[id]) - 1;
    if (c) begin
      m_score[id] = 0;
      m_ovf[id]   = 0;
      busy[id]    = 0;
      flush(id);
    end else if (busy[id] > 0) begin
      busy[id]--;
      if (busy[id] == 0) begin
        m_score[id] = p_score[id];
        m_ovf[id]   = m_ovf[id] | p_ovf[id];
        if (p_score[id] > m_high[id]) m_high[id] = p_score[id];
      end
    end else if (s) begin
      v = m_score[id] + inc_value(inc);
      o = (v > maxv);
      if (o) v = maxv;
      p_score[id] = v;
      p_ovf[id]   = o;
      busy[id]    = DIG[id] + 1;
      e.cyc   = edge_n + DIG[id] + 2;
      e.score = v;
      e.high  = (v > m_high[id]) ? v : m_high[id];
      e.ovf   = m_ovf[id] | o;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_score[id] = 0; m_high[id] = 0; m_ovf[id] = 0; busy[id] = 0;
      p_score[id] = 0; p_ovf[id] = 0;
      flush(id);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic [7:0] inc, input logic sh);
    @(negedge clock);
    #1;
    start = s; clear = c; increment = inc; showHigh = sh;
    model_edge(0, s, c, inc);
    model_edge(1, s, c, inc);
  endtask

  task automatic idle_until_ready(input logic sh);
    for (int t = 0; t < 20 && (busy[0] != 0 || busy[1] != 0); t++) step(1'b0, 1'b0, 8'h00, sh);
    step(1'b0, 1'b0, 8'h00, sh);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: done is compared every cycle; a done pops the scoreboard.
  task automatic mon(input int id);
    exp_t e;
    bit   due;
    due = 0;
    if (qsize(id) > 0) begin
      e   = (id == 0) ? q0[0] : q1[0];
      due = (e.cyc == edge_n);
    end
    check("done", id, 64'(done_w[id]), 64'(due));
    if (due || (done_w[id] && qsize(id) > 0)) begin
      if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      check("done_score", id, 64'(score_w[id]), 64'(to_bcd(e.score, DIG[id])));
      check("done_high", id, 64'(high_w[id]), 64'(to_bcd(e.high, DIG[id])));
      check("done_ovf", id, 64'(ovf_w[id]), 64'(e.ovf));
    end
    check("ready", id, 64'(ready_w[id]), 64'(busy[id] == 0));
    if (busy[id] == 0) begin
      check("score", id, 64'(score_w[id]), 64'(to_bcd(m_score[id], DIG[id])));
      check("high", id, 64'(high_w[id]), 64'(to_bcd(m_high[id], DIG[id])));
      check("overflow", id, 64'(ovf_w[id]), 64'(m_ovf[id]));
      check("display", id, 64'(disp_w[id]),
            64'(exp_disp(showHigh ? m_high[id] : m_score[id], DIG[id], id == 0)));
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    model_reset();
    @(negedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // First add, then carry across digits (small unit saturates here).
    step(1'b1, 1'b0, 8'h07, 1'b0);
    idle_until_ready(1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h95, 1'b0);
    idle_until_ready(1'b0);
    step(1'b1, 1'b0, 8'h07, 1'b0);
    idle_until_ready(1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Clear keeps high score; clear during an add aborts it.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    idle_until_ready(1'b1);

    // Start while busy is ignored; start with clear is dropped.
    step(1'b1, 1'b0, 8'h23, 1'b0);
    step(1'b1, 1'b0, 8'h50, 1'b0);
    idle_until_ready(1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Out-of-range digits clamp to 9; back-to-back start in the done cycle.
    step(1'b1, 1'b0, 8'hAF, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hF3, 1'b0);
    idle_until_ready(1'b1);

    // Reset in the middle of an add.
    step(1'b1, 1'b0, 8'h33, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    idle_until_ready(1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
